serial_slave_port: RTL and testbench

- Responder end of the serial system bus.
- Sits between the address decoder / bus mux and one slave memory device. Deserialises the memory address and write data shifted out by a master port, and performs a single-cycle parallel access to local memory.
- For reads, serialises the read word back to the master with svalid framing.
- Optionally asserts split while the memory is slow.

---
 rtl/serial_slave_port.sv | 170 +++++++++++++++++
 tb/tb_serial_slave_port.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_slave_port.sv
// serial_slave_port: serial bus responder; deserialises address/write data, serialises read data (split support under SERIAL_SLAVE_SPLIT_EN)
module serial_slave_port #(
  parameter int ADDR_WIDTH      = 12,
  parameter int DATA_WIDTH      = 8,
  parameter int SPLIT_THRESHOLD = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  swdata,
  input  logic                  smode,
  input  logic                  mvalid,
  output logic                  srdata,
  output logic                  svalid,
  output logic                  sready,
  output logic                  ssplit,
  input  logic                  split_grant,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_wen,
  output logic                  mem_ren,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_rvalid
);
  localparam int MAXW = ADDR_WIDTH > DATA_WIDTH ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CW   = $clog2(MAXW) + 1;
  typedef enum logic [2:0] {IDLE, ADDR, WDATA, MEMWR, MEMRD, RDATA, SPLIT, GRANT} state_t;
  state_t                state, state_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic [ADDR_WIDTH-2:0] addr, addr_n;
  logic [DATA_WIDTH-2:0] wdata, wdata_n;
  logic [DATA_WIDTH-1:0] rdata, rdata_n;
  logic [ADDR_WIDTH-1:0] mem_addr_n;
  logic [DATA_WIDTH-1:0] mem_wdata_n;
  logic                  srdata_n, svalid_n, ssplit_n, mem_wen_n, mem_ren_n;
`ifdef SERIAL_SLAVE_SPLIT_EN
  localparam int WW = $clog2(SPLIT_THRESHOLD + 1) + 1;
  logic [WW-1:0] wcnt, wcnt_n;
`else
  logic unused;
  assign unused = split_grant ^ (SPLIT_THRESHOLD == 0);
`endif
  assign sready = state == IDLE;
  // next-state and next-output computation; serial words shift in/out LSB first
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    addr_n      = addr;
    wdata_n     = wdata;
    rdata_n     = rdata;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
    srdata_n    = 1'b0;
    svalid_n    = 1'b0;
    ssplit_n    = ssplit;
    mem_wen_n   = 1'b0;
    mem_ren_n   = 1'b0;
`ifdef SERIAL_SLAVE_SPLIT_EN
    wcnt_n      = wcnt;
`endif
    case (state)
      IDLE: if (mvalid) begin
        addr_n  = {swdata, addr[ADDR_WIDTH-2:1]};
        cnt_n   = CW'(1);
        state_n = ADDR;
      end
      ADDR: if (mvalid) begin
        if (cnt == CW'(ADDR_WIDTH - 1)) begin
          cnt_n      = '0;
          mem_addr_n = {swdata, addr};
          mem_ren_n  = !smode;
          state_n    = smode ? WDATA : MEMRD;
`ifdef SERIAL_SLAVE_SPLIT_EN
          wcnt_n     = '0;
`endif
        end else begin
          addr_n = {swdata, addr[ADDR_WIDTH-2:1]};
          cnt_n  = cnt + 1'b1;
        end
      end
      WDATA: if (mvalid) begin
        if (cnt == CW'(DATA_WIDTH - 1)) begin
          cnt_n       = '0;
          mem_wdata_n = {swdata, wdata};
          mem_wen_n   = 1'b1;
          state_n     = MEMWR;
        end else begin
          wdata_n = {swdata, wdata[DATA_WIDTH-2:1]};
          cnt_n   = cnt + 1'b1;
        end
      end
      MEMWR: state_n = IDLE;
      MEMRD: if (mem_rvalid && !mem_ren) begin
        srdata_n = mem_rdata[0];
        svalid_n = 1'b1;
        rdata_n  = mem_rdata >> 1;
        cnt_n    = '0;
        state_n  = RDATA;
      end
`ifdef SERIAL_SLAVE_SPLIT_EN
      else begin
        wcnt_n = wcnt + 1'b1;
        if (wcnt_n == WW'(SPLIT_THRESHOLD)) begin
          ssplit_n = 1'b1;
          state_n  = SPLIT;
        end
      end
`endif
      RDATA: if (cnt == CW'(DATA_WIDTH - 1)) begin
        cnt_n   = '0;
        state_n = IDLE;
      end else begin
        srdata_n = rdata[0];
        svalid_n = 1'b1;
        rdata_n  = rdata >> 1;
        cnt_n    = cnt + 1'b1;
      end
`ifdef SERIAL_SLAVE_SPLIT_EN
      SPLIT: if (mem_rvalid) begin
        rdata_n  = mem_rdata;
        ssplit_n = 1'b0;
        state_n  = GRANT;
      end
      GRANT: if (split_grant) begin
        srdata_n = rdata[0];
        svalid_n = 1'b1;
        rdata_n  = rdata >> 1;
        cnt_n    = '0;
        state_n  = RDATA;
      end
`endif
      default: state_n = IDLE;
    endcase
  end
  // state and registered outputs; reset aborts any transfer without strobes
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      cnt       <= '0;
      addr      <= '0;
      wdata     <= '0;
      rdata     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      srdata    <= 1'b0;
      svalid    <= 1'b0;
      ssplit    <= 1'b0;
      mem_wen   <= 1'b0;
      mem_ren   <= 1'b0;
`ifdef SERIAL_SLAVE_SPLIT_EN
      wcnt      <= '0;
`endif
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      addr      <= addr_n;
      wdata     <= wdata_n;
      rdata     <= rdata_n;
      mem_addr  <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
      srdata    <= srdata_n;
      svalid    <= svalid_n;
      ssplit    <= ssplit_n;
      mem_wen   <= mem_wen_n;
      mem_ren   <= mem_ren_n;
`ifdef SERIAL_SLAVE_SPLIT_EN
      wcnt      <= wcnt_n;
`endif
    end
  end
endmodule

// File: tb/tb_serial_slave_port.sv
// tb_serial_slave_port: randomized scoreboard bench for serial_slave_port (split checks when SERIAL_SLAVE_SPLIT_EN is defined)
module tb_serial_slave_port;
  localparam int THR = 4;
`ifdef SERIAL_SLAVE_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif
  logic        clk = 0, rstn, swdata, smode, mvalid, split_grant, mem_rvalid;
  logic        srdata, svalid, sready, ssplit, mem_wen, mem_ren;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  int checks = 0, failures = 0, cyc = 0, last_bit_cyc = 0, lat = 2;
  int ren_cyc = 0, rv_cyc = 0, gr_cyc = 0, nbits = 0;
  bit split_seen = 0, prev_split = 0, prev_wen = 0;
  logic [7:0]  word;
  logic [19:0] wq[$];
  logic [11:0] renq[$];
  logic [7:0]  rq[$];
  logic [7:0]  model[4096];
  logic [7:0]  mem_arr[4096];

  serial_slave_port dut (
    .clk(clk), .rstn(rstn), .swdata(swdata), .smode(smode), .mvalid(mvalid),
    .srdata(srdata), .svalid(svalid), .sready(sready), .ssplit(ssplit),
    .split_grant(split_grant), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wen(mem_wen), .mem_ren(mem_ren), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", n, a, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [11:0] v, input int n, input int gap_at, input int gap_len, input bit rnd);
    for (int i = 0; i < n; i++) begin
      if (rnd && $urandom_range(0, 3) == 0) begin
        mvalid = 0;
        repeat ($urandom_range(1, 3)) step();
      end
      mvalid = 1;
      swdata = v[i];
      last_bit_cyc = cyc;
      step();
      if (i == gap_at) begin
        mvalid = 0;
        repeat (gap_len) step();
      end
    end
    mvalid = 0;
  endtask

  task automatic wait_ready();
    int t;
    t = 0;
    while (!sready && t < 300) begin
      step();
      t++;
    end
    chk("ready_timeout", t < 300, 1);
  endtask

  task automatic do_write(input logic [11:0] a, input logic [7:0] d, input int ga, input int gla, input int gd, input int gld, input bit rnd);
    wq.push_back({a, d});
    model[a] = d;
    smode = 1;
    send_bits(a, 12, ga, gla, rnd);
    send_bits({4'b0, d}, 8, gd, gld, rnd);
    wait_ready();
  endtask

  task automatic do_read(input logic [11:0] a, input int l, input bit rnd);
    lat = l;
    renq.push_back(a);
    rq.push_back(model[a]);
    smode = 0;
    send_bits(a, 12, -1, 0, rnd);
    wait_ready();
  endtask

  // memory responder: returns stored word `lat` cycles after each read strobe
  initial begin
    logic [11:0] a;
    int l;
    mem_rvalid = 0;
    mem_rdata = 0;
    forever begin
      @(negedge clk);
      if (mem_ren) begin
        a = mem_addr;
        l = lat;
        repeat (l) @(posedge clk);
        #1 mem_rvalid = 1;
        mem_rdata = mem_arr[a];
        @(posedge clk);
        #1 mem_rvalid = 0;
        mem_rdata = 8'($urandom);
      end
    end
  end

`ifdef SERIAL_SLAVE_SPLIT_EN
  // arbiter stand-in: re-grants a few cycles after the split is released
  initial begin
    bit p;
    p = 0;
    forever begin
      @(negedge clk);
      if (p && !ssplit) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        @(posedge clk);
        #1 split_grant = 1;
        @(posedge clk);
        #1 split_grant = 0;
      end
      p = ssplit;
    end
  end
`endif

  // monitor: pops expectations whenever the DUT presents a strobe or serial word
  always @(negedge clk) if (rstn) begin
    if (prev_wen) chk("sready_after_wr", sready, 1);
    prev_wen = mem_wen;
    if (mem_wen) begin
      mem_arr[mem_addr] = mem_wdata;
      if (wq.size() == 0) chk("unexpected_wen", 1, 0);
      else begin
        logic [19:0] e;
        e = wq.pop_front();
        chk("wr_addr", mem_addr, e[19:8]);
        chk("wr_data", mem_wdata, e[7:0]);
        chk("wr_latency", cyc, last_bit_cyc + 1);
      end
    end
    if (mem_ren) begin
      ren_cyc = cyc;
      if (renq.size() == 0) chk("unexpected_ren", 1, 0);
      else begin
        chk("rd_addr", mem_addr, renq.pop_front());
        chk("ren_latency", cyc, last_bit_cyc + 1);
      end
    end
    if (ssplit && !prev_split) begin
      split_seen = 1;
      chk("split_rise", cyc, ren_cyc + THR);
    end
    if (!ssplit && prev_split) chk("split_fall", cyc, rv_cyc + 1);
    prev_split = ssplit;
    if (mem_rvalid) begin
      rv_cyc = cyc;
      chk("split_expect", split_seen, SPLIT && lat >= THR);
    end
    if (split_grant) gr_cyc = cyc;
    if (svalid) begin
      if (nbits == 0) chk("rd_start", cyc, (split_seen ? gr_cyc : rv_cyc) + 1);
      if (nbits < 8) word[nbits] = srdata;
      nbits++;
    end else if (nbits > 0) begin
      chk("rd_bits", nbits, 8);
      if (rq.size() == 0) chk("unexpected_rd", 1, 0);
      else chk("rd_word", word, rq.pop_front());
      nbits = 0;
      split_seen = 0;
    end
  end

  initial begin
    rstn = 0; mvalid = 0; swdata = 0; smode = 0; split_grant = 0;
    for (int a = 0; a < 4096; a++) begin
      model[a] = 8'(a * 7 + 3);
      mem_arr[a] = 8'(a * 7 + 3);
    end
    model[12'h123] = 8'hB7;
    mem_arr[12'h123] = 8'hB7;
    repeat (3) step();
    chk("rst_sready", sready, 1);
    chk("rst_svalid", svalid, 0);
    chk("rst_wen", mem_wen, 0);
    chk("rst_ren", mem_ren, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_ssplit", ssplit, 0);
    rstn = 1;
    step();
    do_write(12'hA5C, 8'h3E, -1, 0, -1, 0, 0);
    do_read(12'h123, 2, 0);
    do_write(12'h5C3, 8'h9D, 5, 3, 2, 3, 0);
    do_read(12'h5C3, 1, 0);
    smode = 1;
    send_bits(12'h3C7, 12, -1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      mvalid = 1;
      swdata = i[0];
      step();
    end
    swdata = 1;
    #1 rstn = 0;
    #1;
    chk("arst_sready", sready, 1);
    chk("arst_wen", mem_wen, 0);
    chk("arst_addr", mem_addr, 0);
    chk("arst_wdata", mem_wdata, 0);
    chk("arst_srdata", srdata, 0);
    chk("arst_svalid", svalid, 0);
    mvalid = 0;
    repeat (2) step();
    rstn = 1;
    step();
    do_write(12'h001, 8'hFF, -1, 0, -1, 0, 0);
    do_read(12'h001, 3, 0);
    do_read(12'hA5C, 10, 0);
    do_read(12'h123, 2, 0);
    for (int k = 0; k < 40; k++) begin
      logic [11:0] a;
      a = 12'($urandom_range(0, 31) * 97);
      if ($urandom_range(0, 1) == 1) do_write(a, 8'($urandom), -1, 0, -1, 0, 1);
      else do_read(a, $urandom_range(1, 12), 1);
    end
    repeat (3) step();
    chk("wq_empty", wq.size(), 0);
    chk("renq_empty", renq.size(), 0);
    chk("rq_empty", rq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1);
  end
endmodule
